// File: rtl/output_port_rr_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : output_port_rr_arbiter_if
// Description : Handshake bundle between the per-port arbiter and the channel
//               side of the router output port.
//               master : drives req/rok/last/wok, observes the grant side
//               slave  : the arbiter (consumes req/rok/last/wok,
//                        produces gnt/busy/xfer/eop/timeout)
//               Signals:
//                 req     [N] head flit of channel routed to this port
//                 rok     [N] channel FIFO has data to read
//                 last    [N] tlast of the channel's current head flit
//                 wok         downstream can accept a beat
//                 gnt     [N] one-hot grant (zero when idle)
//                 busy        a packet currently holds the port
//                 xfer        a beat moves this cycle
//                 eop         the tlast beat moves this cycle
//                 timeout     one-cycle pulse when a stalled grant is dropped
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface output_port_rr_arbiter_if #(
    parameter int NUMBER_CHANNELS = 5
);
    logic [NUMBER_CHANNELS-1:0] req;
    logic [NUMBER_CHANNELS-1:0] rok;
    logic [NUMBER_CHANNELS-1:0] last;
    logic                       wok;
    logic [NUMBER_CHANNELS-1:0] gnt;
    logic                       busy;
    logic                       xfer;
    logic                       eop;
    logic                       timeout;

    modport master (
        output req, rok, last, wok,
        input  gnt, busy, xfer, eop, timeout
    );

    modport slave (
        input  req, rok, last, wok,
        output gnt, busy, xfer, eop, timeout
    );
endinterface

`default_nettype wire

// File: rtl/output_port_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : output_port_rr_arbiter
// Description : Round-robin, packet-locking (wormhole) arbiter sharing one
//               router output port among NUMBER_CHANNELS input channels.
//               The grant is taken in IDLE from the first requester at or
//               after the priority pointer and held until the tlast beat
//               moves; the pointer then advances past the served channel.
//               Optional feature macro: ARB_TIMEOUT_EN - drops a grant that
//               has not moved a beat for TIMEOUT_CYCLES cycles.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - output_port_rr_arbiter_if.slave
//                       (req/rok/last/wok in, gnt/busy/xfer/eop/timeout out)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module output_port_rr_arbiter #(
    parameter int NUMBER_CHANNELS = 5,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input wire clk,
    input wire rst_n,
    output_port_rr_arbiter_if.slave bus
);

    localparam int c_idx_w = (NUMBER_CHANNELS > 1) ? $clog2(NUMBER_CHANNELS) : 1;
    // One extra bit so ptr + offset cannot overflow before the wrap subtract.
    localparam int c_sum_w = c_idx_w + 1;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0]                 r_state;
    logic [c_idx_w-1:0]         r_ptr;
    logic [c_idx_w-1:0]         r_gidx;
    logic [NUMBER_CHANNELS-1:0] r_gnt;
    logic                       r_busy;

    logic                       w_xfer;
    logic                       w_eop;
    logic                       w_stall_expire;
    logic                       w_found;
    logic [c_idx_w-1:0]         w_winner;
    logic [c_sum_w-1:0]         w_cand;
    logic [NUMBER_CHANNELS-1:0] w_winner_oh;
    logic [c_idx_w-1:0]         w_ptr_next;

    // A beat only moves on the granted lane, so masking with the one-hot
    // grant is enough; when idle the grant is zero and nothing moves.
    assign w_xfer = bus.wok & (|(r_gnt & bus.rok));
    assign w_eop  = w_xfer & (|(r_gnt & bus.last));

    // Circular search starting at the pointer; the first hit wins.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int i = 0; i < NUMBER_CHANNELS; i++) begin
            w_cand = {1'b0, r_ptr} + c_sum_w'(i);
            if (w_cand >= c_sum_w'(NUMBER_CHANNELS)) begin
                w_cand = w_cand - c_sum_w'(NUMBER_CHANNELS);
            end
            if (!w_found && bus.req[w_cand[c_idx_w-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[c_idx_w-1:0];
            end
        end
    end

    always_comb begin
        w_winner_oh           = '0;
        w_winner_oh[w_winner] = 1'b1;
    end

    // Priority moves to the channel just after the one that was served.
    assign w_ptr_next = (r_gidx == c_idx_w'(NUMBER_CHANNELS - 1)) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_gnt   <= w_winner_oh;
                        r_gidx  <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= c_st_grant;
                    end
                end
                c_st_grant: begin
                    // Requests are ignored here: the packet owns the port
                    // until its last beat moves (or it is timed out).
                    if (w_eop || w_stall_expire) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int c_stall_w = $clog2(TIMEOUT_CYCLES) + 1;

    logic [c_stall_w-1:0] r_stall;
    logic                 r_timeout;

    // The cycle that finds the counter at its limit with no beat moving is
    // the last stalled cycle tolerated; the next edge releases the grant.
    assign w_stall_expire = (r_state == c_st_grant) && !w_xfer &&
                            (r_stall == c_stall_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_stall_expire;
            if ((r_state != c_st_grant) || w_xfer || w_stall_expire) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_stall_expire = 1'b0;
    assign bus.timeout    = 1'b0;
`endif

    assign bus.gnt  = r_gnt;
    assign bus.busy = r_busy;
    assign bus.xfer = w_xfer;
    assign bus.eop  = w_eop;

endmodule

`default_nettype wire

// File: tb/tb_output_port_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_output_port_rr_arbiter
// Description : Self-checking bench for output_port_rr_arbiter. A queue-free
//               behavioural model (owner index, pointer, stall count) predicts
//               gnt/busy/xfer/eop/timeout every cycle; directed scenarios add
//               hand-computed literal expectations, then a randomized run.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_output_port_rr_arbiter;

    localparam int N  = 5;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    output_port_rr_arbiter_if #(.NUMBER_CHANNELS(N)) bus ();

    output_port_rr_arbiter #(
        .NUMBER_CHANNELS(N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who owns the port, where priority starts, stall length,
    // beats moved in the current packet, and the pending timeout pulse.
    bit m_busy;
    int m_g;
    int m_ptr;
    int m_stall;
    int m_beats;
    bit m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_g     = 0;
        m_ptr   = 0;
        m_stall = 0;
        m_beats = 0;
        m_to    = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        bit ex;
        bit ee;
        eg = '0;
        if (m_busy) eg[m_g] = 1'b1;
        ex = m_busy && bus.wok && bus.rok[m_g];
        ee = ex && bus.last[m_g];
        check("gnt",     32'(bus.gnt),     32'(eg));
        check("busy",    32'(bus.busy),    32'(m_busy));
        check("xfer",    32'(bus.xfer),    32'(ex));
        check("eop",     32'(bus.eop),     32'(ee));
        check("timeout", 32'(bus.timeout), 32'(m_to));
    endtask

    task automatic model_step();
        bit ex;
        bit ee;
        int c;
        ex = m_busy && bus.wok && bus.rok[m_g];
        ee = ex && bus.last[m_g];
        m_to = 1'b0;
        if (!m_busy) begin
            m_stall = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (bus.req[c]) begin
                    m_busy  = 1'b1;
                    m_g     = c;
                    m_beats = 0;
                    break;
                end
            end
        end else if (ee) begin
            m_busy  = 1'b0;
            m_ptr   = (m_g + 1) % N;
            m_stall = 0;
        end else begin
            if (ex) m_beats++;
`ifdef ARB_TIMEOUT_EN
            if (ex) begin
                m_stall = 0;
            end else if (m_stall == TO - 1) begin
                m_busy  = 1'b0;
                m_ptr   = (m_g + 1) % N;
                m_to    = 1'b1;
                m_stall = 0;
            end else begin
                m_stall++;
            end
`endif
        end
    endtask

    // Inputs change just after a falling edge; outputs are compared 1 time
    // unit later and the model advances to the state after the next rise.
    task automatic tick();
        #1;
        check_outputs();
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] k,
                          input logic [N-1:0] l, input logic w);
        bus.req  = r;
        bus.rok  = k;
        bus.last = l;
        bus.wok  = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in('0, '0, '0, 1'b0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    int           order [6] = '{0, 1, 2, 3, 4, 0};
    int           n_seen;
    logic [N-1:0] prev_gnt;
    logic [N-1:0] exp_oh;

    initial begin
        model_reset();
        set_in('0, '0, '0, 1'b0);
        @(negedge clk);

        // Reset and idle
        do_reset();
        check("rst_gnt",  32'(bus.gnt),  32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 10; i++) tick();

        // Single requester, 3-beat packet on ch2
        set_in(5'b00100, 5'b00100, 5'b00000, 1'b1);
        check("sr_gnt_lat0", 32'(bus.gnt), 32'h0);
        tick();
        check("sr_gnt", 32'(bus.gnt), 32'b00100);
        tick();
        tick();
        set_in(5'b00000, 5'b00100, 5'b00100, 1'b1);
        #1 check("sr_eop", 32'(bus.eop), 32'h1);
        tick();
        check("sr_release", 32'(bus.gnt), 32'h0);
        set_in(5'b11111, 5'b00000, 5'b00000, 1'b1);
        tick();
        check("sr_ptr3", 32'(bus.gnt), 32'b01000);
        set_in(5'b00000, 5'b01000, 5'b01000, 1'b1);
        tick();
        tick();

        // Round-robin with all channels requesting, 2-beat packets
        do_reset();
        set_in(5'b11111, 5'b11111, 5'b00000, 1'b1);
        n_seen   = 0;
        prev_gnt = '0;
        for (int i = 0; i < 30 && n_seen < 6; i++) begin
            if (bus.gnt != '0 && prev_gnt == '0) begin
                exp_oh = '0;
                exp_oh[order[n_seen]] = 1'b1;
                check("rr_order", 32'(bus.gnt), 32'(exp_oh));
                n_seen++;
            end
            prev_gnt = bus.gnt;
            bus.last = (m_busy && m_beats == 1) ? '1 : '0;
            tick();
        end
        check("rr_count", 32'(n_seen), 32'd6);

        // Wrap and skip: pointer at 4, only ch0/ch1 request
        do_reset();
        set_in(5'b01000, 5'b01000, 5'b01000, 1'b1);
        tick();
        set_in(5'b00000, 5'b01000, 5'b01000, 1'b1);
        tick();
        set_in(5'b00011, 5'b00011, 5'b00011, 1'b1);
        tick();
        check("wrap_ch0", 32'(bus.gnt), 32'b00001);
        tick();
        tick();
        check("wrap_ch1", 32'(bus.gnt), 32'b00010);
        set_in(5'b00000, 5'b00011, 5'b00011, 1'b1);
        tick();
        tick();

        // Backpressure with the granted request withdrawn
        do_reset();
        set_in(5'b00100, 5'b11111, 5'b00000, 1'b1);
        tick();
        check("bp_gnt", 32'(bus.gnt), 32'b00100);
        set_in(5'b11011, 5'b11111, 5'b00000, 1'b0);
        for (int i = 0; i < 20; i++) tick();
`ifndef ARB_TIMEOUT_EN
        check("bp_hold", 32'(bus.gnt), 32'b00100);
`endif
        set_in(5'b00000, 5'b11111, 5'b00100, 1'b1);
        tick();
        tick();
`ifndef ARB_TIMEOUT_EN
        check("bp_done", 32'(bus.gnt), 32'h0);
`endif

`ifdef ARB_TIMEOUT_EN
        // Stalled grant is dropped after TO cycles, pointer moves past it
        do_reset();
        set_in(5'b00010, 5'b00000, 5'b00000, 1'b1);
        tick();
        check("to_gnt", 32'(bus.gnt), 32'b00010);
        bus.req = 5'b00100;
        for (int i = 0; i < TO; i++) tick();
        check("to_release", 32'(bus.gnt),     32'h0);
        check("to_pulse",   32'(bus.timeout), 32'h1);
        tick();
        check("to_next",    32'(bus.gnt),     32'b00100);
        check("to_clear",   32'(bus.timeout), 32'h0);
`endif

        // Reset asserted in the middle of a packet
        do_reset();
        set_in(5'b00100, 5'b00000, 5'b00000, 1'b1);
        tick();
        check("mr_gnt", 32'(bus.gnt), 32'b00100);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mr_gnt_drop",  32'(bus.gnt),  32'h0);
        check("mr_busy_drop", 32'(bus.busy), 32'h0);
        tick();
        rst_n = 1'b1;
        set_in(5'b10001, 5'b00000, 5'b00000, 1'b1);
        tick();
        check("mr_ptr0", 32'(bus.gnt), 32'b00001);

        // Randomized traffic; second half starves rok to provoke long stalls
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.req  = N'($urandom);
            bus.rok  = (i < 1500) ? N'($urandom | $urandom) : N'($urandom & $urandom & $urandom);
            bus.last = N'($urandom & $urandom);
            bus.wok  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/output_port_rr_arbiter.md
Name: output_port_rr_arbiter

Overview:
- Per-output-port packet arbiter for the AXI router.
- Shares one output port among NUMBER_CHANNELS input channels.
- Issues a one-hot grant using round-robin priority and holds it for a whole packet (wormhole lock) until the tlast beat is transferred.
- Its gnt output drives the port's valid-switch and data mux; it also emits a transfer strobe.

Parameters:
- NUMBER_CHANNELS, 5, number of input channels competing for the port (2..16).
- TIMEOUT_CYCLES, 256, stall limit used only when ARB_TIMEOUT_EN is defined (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUMBER_CHANNELS  per-channel request: head flit routed to this port.
- rok  input  NUMBER_CHANNELS  per-channel FIFO has data to read.
- last  input  NUMBER_CHANNELS  per-channel tlast of the current head flit.
- wok  input  1  downstream can accept a beat (tready).
- gnt  output  NUMBER_CHANNELS  registered one-hot grant; all-zero when idle.
- busy  output  1  registered; 1 while a packet holds the port.
- xfer  output  1  combinational; a beat moves this cycle.
- eop  output  1  combinational; the tlast beat moves this cycle.
- timeout  output  1  registered, one-cycle pulse; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, busy=0, timeout=0.
  - Priority pointer ptr=0; state=IDLE; stall counter=0.
- Definitions:
  - xfer = wok & |(gnt & rok).
  - eop = xfer & |(gnt & last).
- FSM, two states.
- IDLE:
  - If req==0: stay in IDLE.
  - Otherwise select the first asserted req bit searching ptr, ptr+1, ..., NUMBER_CHANNELS-1, 0, ..., ptr-1 (wrap-around).
  - Next cycle: gnt = one-hot of the winner, busy=1, state=GRANT.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - gnt and busy are held regardless of req changes, including deassertion of the granted req (wormhole lock).
  - On eop: next cycle gnt=0, busy=0, state=IDLE, and ptr = granted index + 1, wrapping NUMBER_CHANNELS-1 to 0.
  - There is a mandatory 1-cycle IDLE bubble between packets.
- ptr changes only on eop, or on timeout when that feature is enabled.
- Single-beat packet (last set on the first beat): grant lasts exactly 1 cycle if wok and rok are both 1.
- req bits for channels not granted are ignored while in GRANT; no preemption.
- Simultaneous requests: winner is the closest to ptr; all requesters are served within NUMBER_CHANNELS packets (fairness bound).
- rok=0 or wok=0 while granted: xfer=0, state and grant are held, no data is lost.
- Reset mid-packet: grant drops immediately (async); ptr returns to 0.
- gnt is never multi-hot; it may be nonzero only when busy=1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A stall counter (width clog2(TIMEOUT_CYCLES)+1) increments each GRANT cycle with xfer=0.
  - It clears on xfer and in IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 without xfer, the next cycle behaves as eop: grant released, state=IDLE, ptr advanced past the stalled channel, timeout=1 for one cycle.
- When not defined:
  - No counter exists; timeout is tied to 0.
  - Grants are held indefinitely until eop.

Test Plan:
- Reset/idle: rst_n low then high, req=0 for 10 cycles -> gnt=0, busy=0, xfer=0 throughout.
- Single requester: req=5'b00100, rok=5'b00100, wok=1, last on 3rd beat -> gnt=5'b00100 one cycle after req, xfer high 3 cycles, gnt=0 the cycle after eop, ptr=3.
- Round-robin fairness: req=5'b11111 held, every packet 2 beats, wok=1 -> grant order ch0, ch1, ch2, ch3, ch4, ch0, each separated by one idle cycle.
- Wrap and skip: ptr=4, req=5'b00011 -> ch0 granted; after its eop -> ch1 granted.
- Backpressure/lock: granted ch2, wok=0 for 20 cycles, req of ch2 deasserted, req=5'b11011 on others -> gnt stays 5'b00100, xfer=0, no eop; resume wok=1 -> packet completes normally. Run with ARB_TIMEOUT_EN undefined.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): granted ch1, rok=0 -> timeout pulses, gnt released after 8 stalled cycles, next grant goes to ch2 if requesting. Reset asserted mid-packet -> gnt=0 immediately.
